// File: rtl/instr_frame_pkg.sv
// Shared definitions for the instruction frame processor: frame layout, opcodes,
// error codes, FSM encoding and small helpers.
package instr_frame_pkg;

    localparam int unsigned FRAME_W = 64;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HDR_W   = FRAME_W - BYTE_W;
    localparam int unsigned CNT_W   = 16;

    // Field LSB positions inside a 64-bit frame
    localparam int unsigned OPC_POS  = 56;
    localparam int unsigned ADDR_POS = 48;
    localparam int unsigned DATA_POS = 16;
    localparam int unsigned SEQ_POS  = 8;
    localparam int unsigned CHK_POS  = 0;

    localparam logic [BYTE_W-1:0] OP_WRITE  = 8'h01;
    localparam logic [BYTE_W-1:0] OP_READ   = 8'h02;
    localparam logic [BYTE_W-1:0] OP_PING   = 8'h03;
    localparam logic [BYTE_W-1:0] OP_ERR    = 8'hEE;
    localparam logic [BYTE_W-1:0] RESP_FLAG = 8'h80;

    localparam logic [BYTE_W-1:0] ERR_NONE = 8'h00;
    localparam logic [BYTE_W-1:0] ERR_CHK  = 8'h01;
    localparam logic [BYTE_W-1:0] ERR_OPC  = 8'h02;
    localparam logic [BYTE_W-1:0] ERR_ADDR = 8'h03;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK     = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4,
        SEND    = 3'd5
    } state_t;

    // Saturating increment for the frame/error counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Assemble the 56-bit header (everything above chk) from its fields
    function automatic logic [HDR_W-1:0] hdr_pack(
        input logic [BYTE_W-1:0] opc,
        input logic [BYTE_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic [BYTE_W-1:0] seq
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[OPC_POS  +: BYTE_W] = opc;
        f[ADDR_POS +: BYTE_W] = addr;
        f[DATA_POS +: DATA_W] = data;
        f[SEQ_POS  +: BYTE_W] = seq;
        return f[FRAME_W-1 -: HDR_W];
    endfunction

endpackage

// File: rtl/frame_chk.sv
// Frame checksum: XOR of the seven header bytes. Used both to verify received
// frames and to generate the chk byte of responses.
module frame_chk
    import instr_frame_pkg::*;
(
    input  logic [HDR_W-1:0]  i_hdr,
    output logic [BYTE_W-1:0] o_chk
);

    always_comb begin
        o_chk = '0;
        for (int i = 0; i < int'(HDR_W / BYTE_W); i++) begin
            o_chk = o_chk ^ i_hdr[i*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/instr_frame_proc.sv
// Instruction frame processor: accepts command frames from the SPI slave stage,
// executes WRITE/READ/PING on a small register file and returns a response frame.
module instr_frame_proc
    import instr_frame_pkg::*;
#(
    parameter int unsigned NREG    = 16,
    parameter int unsigned ACK_TMO = 255
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [63:0]         RX_DATA,
    input  logic                RX_VALID,
    output logic                RX_RD,
    output logic [63:0]         TX_DATA,
    output logic                TX_WR,
    input  logic                TX_BUSY,
    output logic                CFG_WE,
    output logic [7:0]          CFG_ADDR,
    output logic [31:0]         CFG_WDATA,
    output logic [15:0]         FRAME_CNT,
    output logic [15:0]         ERR_CNT
);

    localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned TMO_W = $clog2(ACK_TMO + 1);

    state_t              r_state,     w_state_nxt;
    logic [FRAME_W-1:0]  r_frame,     w_frame_nxt;
    logic                r_rx_rd,     w_rx_rd_nxt;
    logic                r_tx_wr,     w_tx_wr_nxt;
    logic                r_cfg_we,    w_cfg_we_nxt;
    logic [FRAME_W-1:0]  r_tx_data,   w_tx_data_nxt;
    logic [BYTE_W-1:0]   r_cfg_addr,  w_cfg_addr_nxt;
    logic [DATA_W-1:0]   r_cfg_wdata, w_cfg_wdata_nxt;
    logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt_nxt;
    logic [CNT_W-1:0]    r_err_cnt,   w_err_cnt_nxt;
    logic [TMO_W-1:0]    r_tmo_cnt,   w_tmo_cnt_nxt;
    logic                r_stale,     w_stale_nxt;
    logic                w_reg_we;
    logic [DATA_W-1:0]   r_regs [NREG];

    logic [BYTE_W-1:0]   w_opc;
    logic [BYTE_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [BYTE_W-1:0]   w_seq;
    logic [BYTE_W-1:0]   w_chk;
    logic [BYTE_W-1:0]   w_chk_calc;
    logic                w_opc_ok;
    logic                w_addr_ok;
    logic                w_needs_addr;
    logic [BYTE_W-1:0]   w_err_code;
    logic [AW-1:0]       w_ridx;
    logic [DATA_W-1:0]   w_rdata;
    logic [BYTE_W-1:0]   w_resp_opc;
    logic [DATA_W-1:0]   w_resp_data;
    logic [HDR_W-1:0]    w_resp_hdr;
    logic [BYTE_W-1:0]   w_resp_chk;

    // Field extraction from the latched frame
    assign w_opc  = r_frame[OPC_POS  +: BYTE_W];
    assign w_addr = r_frame[ADDR_POS +: BYTE_W];
    assign w_data = r_frame[DATA_POS +: DATA_W];
    assign w_seq  = r_frame[SEQ_POS  +: BYTE_W];
    assign w_chk  = r_frame[CHK_POS  +: BYTE_W];

    frame_chk u_chk_rx (
        .i_hdr (r_frame[FRAME_W-1 -: HDR_W]),
        .o_chk (w_chk_calc)
    );

    assign w_opc_ok     = (w_opc == OP_WRITE) || (w_opc == OP_READ) || (w_opc == OP_PING);
    assign w_needs_addr = (w_opc == OP_WRITE) || (w_opc == OP_READ);
    assign w_addr_ok    = (32'(w_addr) < NREG);
    assign w_ridx       = w_addr[AW-1:0];
    assign w_rdata      = w_addr_ok ? r_regs[w_ridx] : '0;

    // Classification priority: checksum, then opcode, then address range
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_chk_calc != w_chk) begin
            w_err_code = ERR_CHK;
        end else if (!w_opc_ok) begin
            w_err_code = ERR_OPC;
        end else if (w_needs_addr && !w_addr_ok) begin
            w_err_code = ERR_ADDR;
        end
    end

    // Response frame; the read path sees the register file before this frame's write
    always_comb begin
        w_resp_opc  = w_opc | RESP_FLAG;
        w_resp_data = w_data;
        if (w_err_code != ERR_NONE) begin
            w_resp_opc  = OP_ERR;
            w_resp_data = {24'h0, w_err_code};
        end else if (w_opc == OP_READ) begin
            w_resp_data = w_rdata;
        end
    end

    assign w_resp_hdr = hdr_pack(w_resp_opc, w_addr, w_resp_data, w_seq);

    frame_chk u_chk_tx (
        .i_hdr (w_resp_hdr),
        .o_chk (w_resp_chk)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame;
        w_rx_rd_nxt     = r_rx_rd;
        w_tx_wr_nxt     = 1'b0;
        w_cfg_we_nxt    = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_cfg_addr_nxt  = r_cfg_addr;
        w_cfg_wdata_nxt = r_cfg_wdata;
        w_frame_cnt_nxt = r_frame_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_stale_nxt     = r_stale && RX_VALID;
        w_reg_we        = 1'b0;

        case (r_state)
            IDLE: begin
                // A frame abandoned by timeout is not re-accepted until RX_VALID drops
                if (RX_VALID && !r_stale) begin
                    w_frame_nxt   = RX_DATA;
                    w_rx_rd_nxt   = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = ACK;
                end
            end
            ACK: begin
                if (!RX_VALID) begin
                    w_rx_rd_nxt = 1'b0;
                    w_state_nxt = DECODE;
                end else if (r_tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
                    w_rx_rd_nxt   = 1'b0;
                    w_err_cnt_nxt = sat_inc(r_err_cnt);
                    w_stale_nxt   = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            DECODE: begin
                w_frame_cnt_nxt = sat_inc(r_frame_cnt);
                w_tx_data_nxt   = {w_resp_hdr, w_resp_chk};
                if ((w_err_code == ERR_NONE) && (w_opc == OP_WRITE)) begin
                    w_cfg_we_nxt    = 1'b1;
                    w_cfg_addr_nxt  = w_addr;
                    w_cfg_wdata_nxt = w_data;
                    w_reg_we        = 1'b1;
                end
                w_state_nxt = EXEC;
            end
            EXEC: begin
                if (w_err_code != ERR_NONE) begin
                    w_err_cnt_nxt = sat_inc(r_err_cnt);
                end
                w_state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (!TX_BUSY) begin
                    w_tx_wr_nxt = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, output and register-file registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            r_rx_rd     <= 1'b0;
            r_tx_wr     <= 1'b0;
            r_cfg_we    <= 1'b0;
            r_tx_data   <= '0;
            r_cfg_addr  <= '0;
            r_cfg_wdata <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_stale     <= 1'b0;
            r_regs      <= '{default: '0};
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_rx_rd     <= w_rx_rd_nxt;
            r_tx_wr     <= w_tx_wr_nxt;
            r_cfg_we    <= w_cfg_we_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_cfg_addr  <= w_cfg_addr_nxt;
            r_cfg_wdata <= w_cfg_wdata_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_stale     <= w_stale_nxt;
            if (w_reg_we) begin
                r_regs[w_ridx] <= w_data;
            end
        end
    end

    assign RX_RD     = r_rx_rd;
    assign TX_WR     = r_tx_wr;
    assign CFG_WE    = r_cfg_we;
    assign TX_DATA   = r_tx_data;
    assign CFG_ADDR  = r_cfg_addr;
    assign CFG_WDATA = r_cfg_wdata;
    assign FRAME_CNT = r_frame_cnt;
    assign ERR_CNT   = r_err_cnt;

endmodule

// File: doc/instr_frame_proc.md
INSTR_FRAME_PROC -- requirements
Module: instr_frame_proc

Interface
REQ-001 SHALL have parameters: NREG, default 16, register-file depth; ACK_TMO, default 255, max cycles waiting for RX_VALID to drop.
REQ-002 CLK  input  1  clock; all logic on posedge CLK.
REQ-003 RESET_N  input  1  reset, synchronous, active-low.
REQ-004 RX_DATA  input  64  received frame from the SPI slave stage.
REQ-005 RX_VALID  input  1  frame available on RX_DATA.
REQ-006 RX_RD  output  1  consume acknowledge to the SPI slave stage.
REQ-007 TX_DATA  output  64  response frame to the SPI master stage.
REQ-008 TX_WR  output  1  one-cycle send strobe to the SPI master stage.
REQ-009 TX_BUSY  input  1  SPI master stage busy.
REQ-010 CFG_WE  output  1  one-cycle register write strobe.
REQ-011 CFG_ADDR  output  8  register write address.
REQ-012 CFG_WDATA  output  32  register write data.
REQ-013 FRAME_CNT  output  16  frames accepted, saturating at 0xFFFF.
REQ-014 ERR_CNT  output  16  erroneous frames plus ack timeouts, saturating at 0xFFFF.

Function
REQ-015 Frame layout SHALL be: [63:56] opcode, [55:48] addr, [47:16] data, [15:8] seq, [7:0] chk, where chk = XOR of bytes [63:8].
REQ-016 Opcodes SHALL be 0x01 WRITE, 0x02 READ, 0x03 PING; every other opcode is an error.
REQ-017 FSM states SHALL be IDLE, ACK, DECODE, EXEC, WAIT_TX, SEND.
REQ-018 IDLE: on RX_VALID=1, SHALL latch RX_DATA, drive RX_RD=1 and go to ACK in the same edge.
REQ-019 ACK: SHALL hold RX_RD=1 until RX_VALID=0, then drive RX_RD=0 and go to DECODE.
REQ-020 ACK: if RX_VALID stays 1 for ACK_TMO cycles, SHALL drop RX_RD, increment ERR_CNT and return to IDLE with no response.
REQ-021 DECODE (1 cycle): SHALL increment FRAME_CNT and classify the frame: checksum mismatch, unknown opcode, or addr >= NREG for WRITE/READ is an error; priority is checksum, then opcode, then addr.
REQ-022 EXEC (1 cycle), WRITE: SHALL update the internal register and pulse CFG_WE=1 with CFG_ADDR=addr and CFG_WDATA=data.
REQ-023 EXEC SHALL build the response: opcode|0x80, addr, data (READ: register contents; WRITE: the written data; PING: the echoed data), seq echoed, recomputed chk.
REQ-024 EXEC, error: SHALL build response opcode 0xEE, addr echoed, data {24'h0, code}, code 1=checksum 2=opcode 3=addr, seq echoed, valid chk; SHALL increment ERR_CNT and leave registers unchanged.
REQ-025 WAIT_TX: SHALL go to SEND on the first cycle TX_BUSY=0.
REQ-026 SEND: SHALL pulse TX_WR=1 for exactly one cycle and return to IDLE on the next edge.
REQ-027 TX_DATA SHALL be driven stable from EXEC until the next EXEC.
REQ-028 A new RX_VALID SHALL NOT be accepted before the prior response has been sent; RX_VALID arriving during DECODE..SEND is served from IDLE.
REQ-029 Latency SHALL be RX_VALID falling -> TX_WR pulse = 4 cycles with TX_BUSY=0.
REQ-030 Counters SHALL saturate, never wrap; when a frame errors, FRAME_CNT and ERR_CNT SHALL both increment.
REQ-031 A READ immediately after a WRITE to the same addr SHALL return the new value.

Reset
REQ-032 When RESET_N=0, the block SHALL force state IDLE, RX_RD=0, TX_WR=0, CFG_WE=0, TX_DATA=0, CFG_ADDR=0, CFG_WDATA=0, FRAME_CNT=0, ERR_CNT=0, and all registers to 0.
REQ-033 Reset asserted in any state SHALL abort the frame on the next edge with no TX_WR or CFG_WE pulse.

Structure
REQ-034 A shared package instr_frame_pkg SHALL hold the opcode constants, error codes, the 0xEE error opcode, the 0x80 response flag, field bit positions and the FSM state encoding.
REQ-035 The block SHALL contain one sub-module, frame_chk, a combinational 7-byte XOR used for both checking and generating chk.

Verification
REQ-036 Verification SHALL cover WRITE 0x01/addr 0x05/data 0xDEADBEEF/seq 0x11, valid chk -> CFG_WE pulse with addr 0x05 and data 0xDEADBEEF, then TX_WR with TX_DATA[63:56]=0x81 and seq 0x11.
REQ-037 Verification SHALL cover READ addr 0x05 after REQ-036 -> TX_DATA[47:16]=0xDEADBEEF, opcode 0x82, FRAME_CNT=2.
REQ-038 Verification SHALL cover a bad chk on a valid opcode -> opcode 0xEE, data 0x00000001, ERR_CNT+1, no CFG_WE.
REQ-039 Verification SHALL cover WRITE with addr 0x20 -> error code 3 and register file unchanged; opcode 0x7F -> error code 2.
REQ-040 Verification SHALL cover TX_BUSY held high 100 cycles after EXEC -> TX_WR fires exactly 1 cycle after TX_BUSY falls, and TX_DATA is stable throughout.
REQ-041 Verification SHALL cover RX_VALID stuck high for 300 cycles -> RX_RD drops after 255 cycles, ERR_CNT+1, no TX_WR; plus reset asserted in WAIT_TX -> no TX_WR and all outputs zero.
